ring_counter_checker: RTL and testbench

- Receive-side companion to the n-bit one-hot ring counter.
- Samples a WIDTH-bit ring word on each valid strobe and decodes it to a binary index.
- Checks one-hot legality and correct rotation: bit k moves to k+1, MSB wraps to bit 0.
- Acquires and holds lock with a flywheel, and counts sequence errors for debug and status.

---
 rtl/ring_pkg.sv | 20 ++
 rtl/ring_counter_checker_if.sv | 28 ++
 rtl/ring_onehot_decode.sv | 30 +++
 rtl/ring_counter_checker.sv | 134 +++++++++++++
 tb/tb_ring_counter_checker.sv | 119 +++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared types and width helpers for one-hot ring producers and consumers.
package ring_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } ring_chk_state_t;

   // Index width for a ring of n bits. A 1-bit index is the minimum, so it is never zero-width.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of a counter that must be able to hold the value n.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ring_counter_checker_if.sv
// Sample/status bundle between a ring source (master) and the ring checker (slave).
interface ring_counter_checker_if
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ERR_W = 8
);
   localparam int unsigned IDX_W = idx_width(WIDTH);

   logic [WIDTH-1:0] ring_i;
   logic             ring_vld_i;
   logic             clr_err_i;
   logic [IDX_W-1:0] idx_o;
   logic             legal_o;
   logic             lock_o;
   logic             err_o;
   logic [ERR_W-1:0] err_cnt_o;

   modport master (
      output ring_i, ring_vld_i, clr_err_i,
      input  idx_o, legal_o, lock_o, err_o, err_cnt_o
   );

   modport slave (
      input  ring_i, ring_vld_i, clr_err_i,
      output idx_o, legal_o, lock_o, err_o, err_cnt_o
   );
endinterface

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot decoder: returns the set-bit index and whether exactly one bit is set.
module ring_onehot_decode
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDX_W = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] ring,
   output logic [IDX_W-1:0] idx,
   output logic             legal
);
   localparam int unsigned CW = cnt_width(WIDTH);

   logic [CW-1:0]    ones;
   logic [IDX_W-1:0] acc;

   // OR-ing indices is exact for one-hot words; multi-hot results are discarded below.
   always_comb begin
      ones = '0;
      acc  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (ring[i]) begin
            ones = ones + 1'b1;
            acc  = acc | IDX_W'(i);
         end
      end
      legal = (ones == CW'(1));
      idx   = legal ? acc : '0;
   end
endmodule

// File: rtl/ring_counter_checker.sv
// Checks a one-hot ring stream for legality and rotation, with flywheel lock and a saturating error count.
module ring_counter_checker
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned LOCK_N = 2,
   parameter int unsigned LOSS_N = 3,
   parameter int unsigned ERR_W  = 8
) (
   input logic                  clk_i,
   input logic                  rst_i,
   ring_counter_checker_if.slave bus
);
   localparam int unsigned IDX_W = idx_width(WIDTH);
   localparam int unsigned GW    = cnt_width(LOCK_N);
   localparam int unsigned BW    = cnt_width(LOSS_N);

   ring_chk_state_t  state;
   logic [IDX_W-1:0] exp_idx;
   logic [GW-1:0]    good_cnt;
   logic [BW-1:0]    bad_cnt;

   logic [IDX_W-1:0] idx_q;
   logic             legal_q;
   logic             lock_q;
   logic             err_q;
   logic [ERR_W-1:0] err_cnt_q;

   logic [IDX_W-1:0] dec_idx;
   logic             dec_legal;
   logic             in_seq;
   logic             bad_hit;
   logic [GW-1:0]    good_nxt;
   logic [BW-1:0]    bad_nxt;

   ring_onehot_decode #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_dec (
      .ring  (bus.ring_i),
      .idx   (dec_idx),
      .legal (dec_legal)
   );

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
      return (v == IDX_W'(WIDTH - 1)) ? '0 : v + 1'b1;
   endfunction

   always_comb begin
      in_seq   = dec_legal && (dec_idx == exp_idx);
      bad_hit  = bus.ring_vld_i && (state == LOCKED) && !in_seq;
      good_nxt = good_cnt + 1'b1;
      bad_nxt  = bad_cnt + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= HUNT;
         exp_idx   <= '0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
         idx_q     <= '0;
         legal_q   <= 1'b0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q <= bad_hit;

         // Clear wins over the old count but never swallows an error arriving on the same cycle.
         if (bus.clr_err_i)
            err_cnt_q <= bad_hit ? ERR_W'(1) : '0;
         else if (bad_hit && (err_cnt_q != '1))
            err_cnt_q <= err_cnt_q + 1'b1;

         if (bus.ring_vld_i) begin
            idx_q   <= dec_idx;
            legal_q <= dec_legal;
            unique case (state)
               HUNT: begin
                  if (dec_legal) begin
                     exp_idx  <= idx_inc(dec_idx);
                     good_cnt <= GW'(1);
                     bad_cnt  <= '0;
                     if (LOCK_N == 1) begin
                        state  <= LOCKED;
                        lock_q <= 1'b1;
                     end else begin
                        state  <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (!dec_legal) begin
                     state <= HUNT;
                  end else if (in_seq) begin
                     good_cnt <= good_nxt;
                     exp_idx  <= idx_inc(exp_idx);
                     if (good_nxt == GW'(LOCK_N)) begin
                        state   <= LOCKED;
                        lock_q  <= 1'b1;
                        bad_cnt <= '0;
                     end
                  end else begin
                     exp_idx  <= idx_inc(dec_idx);
                     good_cnt <= GW'(1);
                  end
               end
               LOCKED: begin
                  // Flywheel: expectation advances regardless of what arrived.
                  exp_idx <= idx_inc(exp_idx);
                  if (in_seq) begin
                     bad_cnt <= '0;
                  end else if (bad_nxt == BW'(LOSS_N)) begin
                     state    <= HUNT;
                     lock_q   <= 1'b0;
                     bad_cnt  <= '0;
                     good_cnt <= '0;
                  end else begin
                     bad_cnt <= bad_nxt;
                  end
               end
               default: begin
                  state  <= HUNT;
                  lock_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.idx_o     = idx_q;
   assign bus.legal_o   = legal_q;
   assign bus.lock_o    = lock_q;
   assign bus.err_o     = err_q;
   assign bus.err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_ring_counter_checker.sv
// Directed bench for ring_counter_checker at WIDTH=4, LOCK_N=2, LOSS_N=3, ERR_W=8.
module tb_ring_counter_checker;
   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   e;

   ring_counter_checker_if #(.WIDTH(4), .ERR_W(8)) bus ();

   ring_counter_checker #(.WIDTH(4), .LOCK_N(2), .LOSS_N(3), .ERR_W(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [3:0] r, input logic v, input logic c);
      bus.ring_i     = r;
      bus.ring_vld_i = v;
      bus.clr_err_i  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_all(input string tag, input int idx, input int legal,
                          input int lock, input int err, input int cnt);
      chk({tag, ".idx"},   32'(bus.idx_o),     idx);
      chk({tag, ".legal"}, 32'(bus.legal_o),   legal);
      chk({tag, ".lock"},  32'(bus.lock_o),    lock);
      chk({tag, ".err"},   32'(bus.err_o),     err);
      chk({tag, ".cnt"},   32'(bus.err_cnt_o), cnt);
   endtask

   initial begin
      rst = 1'b1;
      bus.ring_i = 4'b0000;
      bus.ring_vld_i = 1'b0;
      bus.clr_err_i = 1'b0;
      step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      chk_all("reset", 0, 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
      chk_all("idle", 0, 0, 0, 0, 0);

      // Acquire
      step(4'b0001, 1'b1, 1'b0); chk_all("acq1", 0, 1, 0, 0, 0);
      step(4'b0010, 1'b1, 1'b0); chk_all("acq2", 1, 1, 1, 0, 0);
      step(4'b0100, 1'b1, 1'b0); chk_all("acq3", 2, 1, 1, 0, 0);

      // Wrap and flywheel
      step(4'b1000, 1'b1, 1'b0); chk_all("wrap3", 3, 1, 1, 0, 0);
      step(4'b0001, 1'b1, 1'b0); chk_all("wrap0", 0, 1, 1, 0, 0);
      step(4'b0110, 1'b1, 1'b0); chk_all("multihot", 0, 0, 1, 1, 1);
      step(4'b0100, 1'b1, 1'b0); chk_all("flywheel", 2, 1, 1, 0, 1);

      // Loss of lock, expected index 1 when the bad run starts
      step(4'b1000, 1'b1, 1'b0); chk_all("pre_loss3", 3, 1, 1, 0, 1);
      step(4'b0001, 1'b1, 1'b0); chk_all("pre_loss0", 0, 1, 1, 0, 1);
      step(4'b0000, 1'b1, 1'b0); chk_all("loss1", 0, 0, 1, 1, 2);
      step(4'b0011, 1'b1, 1'b0); chk_all("loss2", 0, 0, 1, 1, 3);
      step(4'b0001, 1'b1, 1'b0); chk_all("loss3", 0, 1, 0, 1, 4);
      step(4'b1000, 1'b1, 1'b0); chk_all("relock1", 3, 1, 0, 0, 4);
      step(4'b0001, 1'b1, 1'b0); chk_all("relock2", 0, 1, 1, 0, 4);

      // Gap: outputs hold with vld low, even with garbage on the ring
      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 1'b0, 1'b0);
         chk_all("gap", 0, 1, 1, 0, 4);
      end
      step(4'b0010, 1'b1, 1'b0); chk_all("post_gap", 1, 1, 1, 0, 4);

      // Drop lock, then misorder while verifying
      step(4'b0000, 1'b1, 1'b0); chk_all("drop1", 0, 0, 1, 1, 5);
      step(4'b0000, 1'b1, 1'b0); chk_all("drop2", 0, 0, 1, 1, 6);
      step(4'b0000, 1'b1, 1'b0); chk_all("drop3", 0, 0, 0, 1, 7);
      step(4'b0000, 1'b1, 1'b0); chk_all("hunt_illegal", 0, 0, 0, 0, 7);
      step(4'b0001, 1'b1, 1'b0); chk_all("verify0", 0, 1, 0, 0, 7);
      step(4'b0100, 1'b1, 1'b0); chk_all("misorder", 2, 1, 0, 0, 7);
      step(4'b1000, 1'b1, 1'b0); chk_all("lock_after_restart", 3, 1, 1, 0, 7);

      // Saturation: bad/good pairs keep lock, one error per pair. Expected index starts at 0.
      e = 0;
      for (int i = 0; i < 249; i++) begin
         step(4'b0000, 1'b1, 1'b0);
         e = (e + 1) % 4;
         step(4'(1 << e), 1'b1, 1'b0);
         e = (e + 1) % 4;
         if (i == 247) chk("cnt_at_255", 32'(bus.err_cnt_o), 255);
      end
      chk_all("saturated", e == 0 ? 3 : e - 1, 1, 1, 0, 255);

      step(4'b0000, 1'b1, 1'b1); e = (e + 1) % 4;
      chk_all("clr_with_err", 0, 0, 1, 1, 1);
      step(4'(1 << e), 1'b1, 1'b0); chk_all("good_after_clr", e, 1, 1, 0, 1);
      e = (e + 1) % 4;
      step(4'b0000, 1'b0, 1'b1); chk_all("clr_alone", e == 0 ? 3 : e - 1, 1, 1, 0, 0);

      // Reset while locked, with a valid in-sequence sample present
      rst = 1'b1;
      step(4'(1 << e), 1'b1, 1'b0); chk_all("rst_locked", 0, 0, 0, 0, 0);
      rst = 1'b0;
      step(4'b0000, 1'b0, 1'b0); chk_all("post_rst", 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
